// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB.
// Presents forwarded A/B operands and store data to the execute stage.
module id_ex_operand_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
  input  logic [WIDTH-1:0]      id_rs_data_i,
  input  logic [WIDTH-1:0]      id_rt_data_i,
  input  logic [15:0]           id_imm_i,
  input  logic                  id_use_imm_i,
  input  logic                  id_zero_ext_i,
  input  logic [2:0]            id_alu_op_i,
  input  logic [REG_ADDR_W-1:0] id_dest_i,
  input  logic                  id_reg_write_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_dest_i,
  input  logic [WIDTH-1:0]      exmem_result_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_dest_i,
  input  logic [WIDTH-1:0]      memwb_result_i,
  output logic                  ex_valid_o,
  output logic [WIDTH-1:0]      ex_a_o,
  output logic [WIDTH-1:0]      ex_b_o,
  output logic [WIDTH-1:0]      ex_store_data_o,
  output logic [2:0]            ex_alu_op_o,
  output logic [REG_ADDR_W-1:0] ex_dest_o,
  output logic                  ex_reg_write_o,
  output logic [1:0]            ex_fwd_a_o,
  output logic [1:0]            ex_fwd_b_o
);

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [WIDTH-1:0]      rs_data_q, rs_data_d;
  logic [WIDTH-1:0]      rt_data_q, rt_data_d;
  logic [WIDTH-1:0]      ext_imm_q, ext_imm_d;
  logic                  use_imm_q, use_imm_d;

  logic [WIDTH-1:0] ext_imm;
  logic             wb_hit_rs, wb_hit_rt;
  logic [WIDTH-1:0] a_fwd, rt_fwd;

  assign ext_imm = id_zero_ext_i ? {{(WIDTH-16){1'b0}}, id_imm_i}
                                 : {{(WIDTH-16){id_imm_i[15]}}, id_imm_i};

  // A value retiring from MEM/WB while held would otherwise be lost once it leaves the pipe.
  assign wb_hit_rs = memwb_reg_write_i && (memwb_dest_i == rs_addr_q) && (rs_addr_q != '0);
  assign wb_hit_rt = memwb_reg_write_i && (memwb_dest_i == rt_addr_q) && (rt_addr_q != '0);

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    alu_op_d    = alu_op_q;
    dest_d      = dest_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    ext_imm_d   = ext_imm_q;
    use_imm_d   = use_imm_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      alu_op_d    = '0;
      dest_d      = '0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      ext_imm_d   = '0;
      use_imm_d   = 1'b0;
    end else if (stall_i) begin
      if (wb_hit_rs) rs_data_d = memwb_result_i;
      if (wb_hit_rt) rt_data_d = memwb_result_i;
    end else begin
      valid_d     = id_valid_i;
      reg_write_d = id_reg_write_i & id_valid_i;
      alu_op_d    = id_alu_op_i;
      dest_d      = id_dest_i;
      rs_addr_d   = id_rs_addr_i;
      rt_addr_d   = id_rt_addr_i;
      rs_data_d   = id_rs_data_i;
      rt_data_d   = id_rt_data_i;
      ext_imm_d   = ext_imm;
      use_imm_d   = id_use_imm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      alu_op_q    <= '0;
      dest_q      <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      ext_imm_q   <= '0;
      use_imm_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      alu_op_q    <= alu_op_d;
      dest_q      <= dest_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      ext_imm_q   <= ext_imm_d;
      use_imm_q   <= use_imm_d;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    ex_fwd_a_o = 2'd0;
    a_fwd      = rs_data_q;
    if (exmem_reg_write_i && (exmem_dest_i == rs_addr_q) && (rs_addr_q != '0)) begin
      ex_fwd_a_o = 2'd2;
      a_fwd      = exmem_result_i;
    end else if (wb_hit_rs) begin
      ex_fwd_a_o = 2'd1;
      a_fwd      = memwb_result_i;
    end
  end

  always_comb begin
    ex_fwd_b_o = 2'd0;
    rt_fwd     = rt_data_q;
    if (exmem_reg_write_i && (exmem_dest_i == rt_addr_q) && (rt_addr_q != '0)) begin
      ex_fwd_b_o = 2'd2;
      rt_fwd     = exmem_result_i;
    end else if (wb_hit_rt) begin
      ex_fwd_b_o = 2'd1;
      rt_fwd     = memwb_result_i;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_a_o          = a_fwd;
  assign ex_b_o          = use_imm_q ? ext_imm_q : rt_fwd;
  assign ex_store_data_o = rt_fwd;
  assign ex_alu_op_o     = alu_op_q;
  assign ex_dest_o       = dest_q;
  assign ex_reg_write_o  = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, load, forwarding priority,
// register 0, immediates, stall refresh and flush priority.
module tb_id_ex_operand_stage;

  localparam logic [2:0] OpAnd = 3'd4;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dest, exmem_dest, memwb_dest;
  logic [31:0] id_rs_data, id_rt_data, exmem_result, memwb_result;
  logic [15:0] id_imm;
  logic        id_use_imm, id_zero_ext, id_reg_write, exmem_reg_write, memwb_reg_write;
  logic [2:0]  id_alu_op;
  logic        ex_valid, ex_reg_write;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_dest;
  logic [1:0]  ex_fwd_a, ex_fwd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
    .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr), .id_rs_data_i(id_rs_data),
    .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_use_imm_i(id_use_imm),
    .id_zero_ext_i(id_zero_ext), .id_alu_op_i(id_alu_op), .id_dest_i(id_dest),
    .id_reg_write_i(id_reg_write), .exmem_reg_write_i(exmem_reg_write),
    .exmem_dest_i(exmem_dest), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_dest_i(memwb_dest),
    .memwb_result_i(memwb_result), .ex_valid_o(ex_valid), .ex_a_o(ex_a), .ex_b_o(ex_b),
    .ex_store_data_o(ex_store_data), .ex_alu_op_o(ex_alu_op), .ex_dest_o(ex_dest),
    .ex_reg_write_o(ex_reg_write), .ex_fwd_a_o(ex_fwd_a), .ex_fwd_b_o(ex_fwd_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [15:0] imm, input logic use_imm,
                         input logic zext, input logic [2:0] op, input logic [4:0] dst,
                         input logic rw, input logic vld);
    id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_imm = imm; id_use_imm = use_imm; id_zero_ext = zext; id_alu_op = op;
    id_dest = dst; id_reg_write = rw; id_valid = vld;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 1'b0; exmem_dest = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_dest = 5'd0; memwb_result = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; no_fwd();
    load_id(5'd9, $urandom, 5'd10, $urandom, 16'h1234, 1'b0, 1'b0, 3'd6, 5'd11, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (ex_valid !== 1'b0) begin n_fail++;
        $display("FAIL reset_valid[%0d]: got %b expected 0", i, ex_valid); end
      n_tests++; if (ex_reg_write !== 1'b0) begin n_fail++;
        $display("FAIL reset_reg_write[%0d]: got %b expected 0", i, ex_reg_write); end
      n_tests++; if (ex_dest !== 5'd0) begin n_fail++;
        $display("FAIL reset_dest[%0d]: got %0d expected 0", i, ex_dest); end
    end
    n_tests++; if (ex_alu_op !== 3'd0) begin n_fail++;
      $display("FAIL reset_alu_op: got %0d expected 0", ex_alu_op); end
    n_tests++; if (ex_a !== 32'h0 || ex_b !== 32'h0) begin n_fail++;
      $display("FAIL reset_operands: got a=%h b=%h expected 0/0", ex_a, ex_b); end
    rst = 1'b0;
  endtask

  task automatic test_plain_load();
    load_id(5'd3, 32'h0000_00F0, 5'd4, 32'h0000_0FF0, 16'h0, 1'b0, 1'b0, OpAnd, 5'd8,
            1'b1, 1'b1);
    step();
    n_tests++; if (ex_a !== 32'h0000_00F0) begin n_fail++;
      $display("FAIL load_a: got %h expected 000000f0", ex_a); end
    n_tests++; if (ex_b !== 32'h0000_0FF0) begin n_fail++;
      $display("FAIL load_b: got %h expected 00000ff0", ex_b); end
    n_tests++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++;
      $display("FAIL load_fwd: got %0d/%0d expected 0/0", ex_fwd_a, ex_fwd_b); end
    n_tests++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_dest !== 5'd8) begin
      n_fail++; $display("FAIL load_ctrl: got v=%b rw=%b d=%0d expected 1/1/8",
                         ex_valid, ex_reg_write, ex_dest); end
    n_tests++; if (ex_alu_op !== OpAnd || ex_store_data !== 32'h0000_0FF0) begin n_fail++;
      $display("FAIL load_op_store: got op=%0d sd=%h expected 4/00000ff0",
               ex_alu_op, ex_store_data); end
  endtask

  task automatic test_double_hazard();
    load_id(5'd5, 32'h0, 5'd6, 32'h66, 16'h0, 1'b0, 1'b0, 3'd2, 5'd9, 1'b1, 1'b1);
    step();
    exmem_reg_write = 1'b1; exmem_dest = 5'd5; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1'b1; memwb_dest = 5'd5; memwb_result = 32'h1234_5678;
    #1;
    n_tests++; if (ex_a !== 32'hAAAA_0000 || ex_fwd_a !== 2'd2) begin n_fail++;
      $display("FAIL hazard_exmem: got a=%h fwd=%0d expected aaaa0000/2", ex_a, ex_fwd_a); end
    n_tests++; if (ex_b !== 32'h66 || ex_fwd_b !== 2'd0) begin n_fail++;
      $display("FAIL hazard_rt_clean: got b=%h fwd=%0d expected 00000066/0", ex_b, ex_fwd_b); end
    exmem_reg_write = 1'b0;
    #1;
    n_tests++; if (ex_a !== 32'h1234_5678 || ex_fwd_a !== 2'd1) begin n_fail++;
      $display("FAIL hazard_memwb: got a=%h fwd=%0d expected 12345678/1", ex_a, ex_fwd_a); end
    no_fwd();
  endtask

  task automatic test_reg0_imm();
    load_id(5'd0, 32'h0, 5'd0, 32'h0, 16'h8001, 1'b1, 1'b0, 3'd1, 5'd2, 1'b1, 1'b1);
    step();
    exmem_reg_write = 1'b1; exmem_dest = 5'd0; exmem_result = 32'hFFFF_FFFF;
    #1;
    n_tests++; if (ex_a !== 32'h0 || ex_fwd_a !== 2'd0) begin n_fail++;
      $display("FAIL reg0_a: got a=%h fwd=%0d expected 00000000/0", ex_a, ex_fwd_a); end
    n_tests++; if (ex_b !== 32'hFFFF_8001) begin n_fail++;
      $display("FAIL imm_sign: got %h expected ffff8001", ex_b); end
    n_tests++; if (ex_store_data !== 32'h0 || ex_fwd_b !== 2'd0) begin n_fail++;
      $display("FAIL reg0_store: got %h fwd=%0d expected 0/0", ex_store_data, ex_fwd_b); end
    id_zero_ext = 1'b1;
    step();
    n_tests++; if (ex_b !== 32'h0000_8001) begin n_fail++;
      $display("FAIL imm_zero: got %h expected 00008001", ex_b); end
    no_fwd();
  endtask

  task automatic test_invalid_slot();
    load_id(5'd3, 32'h1, 5'd4, 32'h2, 16'h0, 1'b0, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0);
    step();
    memwb_reg_write = 1'b1; memwb_dest = 5'd3; memwb_result = 32'hCAFE_0001;
    #1;
    n_tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++;
      $display("FAIL invalid_ctrl: got v=%b rw=%b expected 0/0", ex_valid, ex_reg_write); end
    n_tests++; if (ex_a !== 32'hCAFE_0001 || ex_fwd_a !== 2'd1) begin n_fail++;
      $display("FAIL invalid_fwd: got a=%h fwd=%0d expected cafe0001/1", ex_a, ex_fwd_a); end
    no_fwd();
  endtask

  task automatic test_stall_retire();
    load_id(5'd1, 32'h5, 5'd7, 32'h11, 16'h0, 1'b0, 1'b0, 3'd3, 5'd12, 1'b1, 1'b1);
    step();
    stall = 1'b1;
    memwb_reg_write = 1'b1; memwb_dest = 5'd7; memwb_result = 32'h22;
    load_id(5'd2, 32'h99, 5'd2, 32'h99, 16'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    #1;
    n_tests++; if (ex_store_data !== 32'h22 || ex_fwd_b !== 2'd1) begin n_fail++;
      $display("FAIL stall_pre: got %h fwd=%0d expected 00000022/1", ex_store_data, ex_fwd_b); end
    step();
    no_fwd();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (ex_store_data !== 32'h22 || ex_fwd_b !== 2'd0) begin n_fail++;
        $display("FAIL stall_held[%0d]: got %h fwd=%0d expected 00000022/0",
                 i, ex_store_data, ex_fwd_b); end
      n_tests++; if (ex_valid !== 1'b1 || ex_a !== 32'h5 || ex_dest !== 5'd12) begin n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h d=%0d expected 1/00000005/12",
                 i, ex_valid, ex_a, ex_dest); end
      step();
    end
  endtask

  task automatic test_flush_vs_stall();
    stall = 1'b1; flush = 1'b1;
    step();
    n_tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_dest !== 5'd0) begin
      n_fail++; $display("FAIL flush_stall: got v=%b rw=%b d=%0d expected 0/0/0",
                         ex_valid, ex_reg_write, ex_dest); end
    stall = 1'b0; flush = 1'b0;
    load_id(5'd13, 32'h77, 5'd14, 32'h88, 16'h0, 1'b0, 1'b0, 3'd5, 5'd12, 1'b1, 1'b1);
    step();
    n_tests++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_dest !== 5'd12) begin
      n_fail++; $display("FAIL after_flush_ctrl: got v=%b rw=%b d=%0d expected 1/1/12",
                         ex_valid, ex_reg_write, ex_dest); end
    n_tests++; if (ex_a !== 32'h77 || ex_b !== 32'h88 || ex_alu_op !== 3'd5) begin n_fail++;
      $display("FAIL after_flush_data: got a=%h b=%h op=%0d expected 00000077/00000088/5",
               ex_a, ex_b, ex_alu_op); end
  endtask

  initial begin
    test_reset();
    test_plain_load();
    test_double_hazard();
    test_reg0_imm();
    test_invalid_slot();
    test_stall_retire();
    test_flush_vs_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the 5-stage MIPS datapath.
- Latches decoded operands and control from decode.
- Resolves RAW hazards against EX/MEM and MEM/WB results.
- Presents final 32-bit A/B operands to the ALU bitwise/arithmetic units (AND/OR/add/sub) and store data to MEM.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold current contents.
- flush  input  1  hazard unit: insert bubble.
- id_valid  input  1  decode slot holds a real instruction.
- id_rs_addr  input  REG_ADDR_W  rs index.
- id_rt_addr  input  REG_ADDR_W  rt index.
- id_rs_data  input  WIDTH  register-file rs value.
- id_rt_data  input  WIDTH  register-file rt value.
- id_imm  input  16  instruction immediate.
- id_use_imm  input  1  B operand = extended immediate.
- id_zero_ext  input  1  1 = zero-extend imm, 0 = sign-extend.
- id_alu_op  input  3  ALU operation select, passed through.
- id_dest  input  REG_ADDR_W  destination register.
- id_reg_write  input  1  instruction writes id_dest.
- exmem_reg_write  input  1  EX/MEM instruction writes back.
- exmem_dest  input  REG_ADDR_W  EX/MEM destination.
- exmem_result  input  WIDTH  EX/MEM ALU result.
- memwb_reg_write  input  1  MEM/WB instruction writes back.
- memwb_dest  input  REG_ADDR_W  MEM/WB destination.
- memwb_result  input  WIDTH  MEM/WB writeback value.
- ex_valid  output  1  registered valid.
- ex_a  output  WIDTH  forwarded A operand to ALU.
- ex_b  output  WIDTH  forwarded rt or extended immediate.
- ex_store_data  output  WIDTH  forwarded rt (always, for sw).
- ex_alu_op  output  3  registered ALU op.
- ex_dest  output  REG_ADDR_W  registered destination.
- ex_reg_write  output  1  registered write enable, gated by valid.
- ex_fwd_a  output  2  A source: 0 reg, 1 MEM/WB, 2 EX/MEM (debug/verif).
- ex_fwd_b  output  2  rt source, same encoding.

Behaviour:
- Reset: on rising clk with rst=1, all internal registers cleared; ex_valid=0, ex_reg_write=0, ex_alu_op=0, ex_dest=0, stored operands and imm=0. Combinational outputs follow forwarding from zeroed state. rst has priority over flush and stall.
- Update priority each edge: rst > flush > stall > load.
  - flush: ex_valid←0, ex_reg_write←0, ex_dest←0; other fields don't-care, cleared to 0.
  - stall (no flush): all registers hold, except the held-operand refresh below.
  - load: capture all id_* fields; ex_valid←id_valid; stored reg_write←id_reg_write & id_valid.
- Extended immediate computed at capture: zero_ext ? {16'b0,imm} : {{16{imm[15]}},imm}.
- Forwarding, combinational from stored rs/rt addr/data and current exmem/memwb inputs; zero latency.
  - EX/MEM match: exmem_reg_write & exmem_dest==addr & addr!=0 → exmem_result, code 2.
  - Else MEM/WB match: same conditions with memwb_* → memwb_result, code 1.
  - Else stored data, code 0.
  - EX/MEM wins when both match.
  - Register 0 never forwards; stored value passes through (register file returns 0).
- ex_b = stored use_imm ? ext_imm : forwarded rt. ex_store_data = forwarded rt regardless of use_imm. ex_fwd_b reflects the rt path even when use_imm=1.
- Held-operand refresh: during stall, if memwb_reg_write & memwb_dest==stored rs (non-zero), stored rs_data←memwb_result; same for rt. This applies even if EX/MEM also matches, since EX/MEM stays combinationally prioritised. It prevents losing a value that retires while held.
- Invalid slot (ex_valid=0): forwarding muxes still operate; ex_reg_write forced 0.
- Simultaneous stall+flush → flush.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 and random inputs → ex_valid=0, ex_reg_write=0, ex_dest=0 after each edge.
- Plain load, no hazards: rs=3 data 0x0000_00F0, rt=4 data 0x0000_0FF0, use_imm=0, op=AND → next cycle ex_a=0x0000_00F0, ex_b=0x0000_0FF0, fwd codes 0/0.
- Double hazard priority: stored rs=5, exmem writes r5=0xAAAA_0000, memwb writes r5=0x1234_5678 → ex_a=0xAAAA_0000, ex_fwd_a=2. Drop exmem_reg_write → ex_a=0x1234_5678, ex_fwd_a=1.
- Register 0 and immediate: rs=0 stored 0, exmem writes dest 0 value 0xFFFF_FFFF → ex_a=0, ex_fwd_a=0. imm=0x8001: sign → ex_b=0xFFFF_8001; zero_ext → ex_b=0x0000_8001.
- Stall with retirement: stored rt=7 data 0x11, stall=1, memwb writes r7=0x22 for one cycle then deasserts → ex_store_data stays 0x22 while stall held; ex_valid unchanged.
- Flush vs stall: stall=1 and flush=1 on the same edge with ex_valid=1 → ex_valid=0, ex_reg_write=0. Next edge, no control, id_valid=1 → loads new instruction.
